memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DATA_W, 16, data word width.
REQ-002 Parameter ADDR_W, 16, data-memory word-address width.
REQ-003 Parameter SP_RESET, 16'h07FF, stack pointer value after reset (empty stack).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 opValid  in  1  op fields valid this cycle.
REQ-007 op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH32, 6 POP32; 7 treated as NOP.
REQ-008 addr  in  ADDR_W  effective address from ALU (LOAD/STORE).
REQ-009 storeData  in  32  [15:0] for STORE/PUSH; [31:0] for PUSH32 (PC/flags).
REQ-010 aluData  in  DATA_W  ALU result, passed to write back.
REQ-011 regDst / regWrite  in  3 / 1  destination register and write enable.
REQ-012 dmemAddr / dmemWe / dmemWdata  out  ADDR_W / 1 / DATA_W  data-memory request.
REQ-013 dmemRdata  in  DATA_W  memory read data, valid the cycle after the request (synchronous read).
REQ-014 stall  out  1  upstream holds op fields while high.
REQ-015 wbMemOrReg / wbMemData / wbAluData  out  1 / DATA_W / DATA_W  write-back mux select and operands.
REQ-016 wbRegDst / wbRegWrite  out  3 / 1  forwarded destination and enable.
REQ-017 wbPop32  out  32  assembled POP32 result (PC restore).
REQ-018 stackErr  out  1  one-cycle pulse on pop from empty stack.

Function
REQ-019 FSM SHALL have states IDLE, BEAT2; IDLE accepts ops, BEAT2 issues second word of PUSH32/POP32 then returns to IDLE.
REQ-020 LOAD SHALL drive dmemAddr=addr, dmemWe=0 in accept cycle N; SP unchanged.
REQ-021 STORE SHALL drive dmemAddr=addr, dmemWe=1, dmemWdata=storeData[15:0] in N.
REQ-022 PUSH SHALL write storeData[15:0] at SP in N and set SP=SP-1 at end of N.
REQ-023 POP SHALL read address SP+1 in N and set SP=SP+1 at end of N.
REQ-024 PUSH32 SHALL write [31:16] at SP in N, [15:0] at SP-1 in N+1; SP-=2 total.
REQ-025 POP32 SHALL read SP+1 (low) in N, SP+2 (high) in N+1; SP+=2 total.
REQ-026 stall SHALL be 1 exactly in cycle N of PUSH32/POP32, else 0; op inputs ignored while in BEAT2.
REQ-027 wbMemOrReg, wbAluData, wbRegDst, wbRegWrite SHALL be registered at end of the last beat; single-word ops visible in N+1, 32-bit ops in N+2.
REQ-028 wbMemData SHALL equal dmemRdata in the cycle the write-back controls are visible.
REQ-029 wbRegWrite SHALL be forced 0 for STORE, PUSH, PUSH32, NOP; wbMemOrReg=1 only for LOAD, POP, POP32.
REQ-030 wbPop32 SHALL be {dmemRdata (high), captured low word} in N+2 of POP32.
REQ-031 SP arithmetic SHALL be modulo 2^ADDR_W (wrap-around, no saturation).
REQ-032 POP/POP32 with SP==SP_RESET SHALL pulse stackErr in N and still execute with wrap.
REQ-033 opValid=0 SHALL be NOP: dmemWe=0, wbRegWrite=0 next cycle.

Reset
REQ-034 rst SHALL asynchronously set state IDLE, SP=SP_RESET, all wb* outputs, stall, stackErr and dmemWe to 0.
REQ-035 rst during BEAT2 SHALL abort the second beat; no further memory write SHALL occur.

Structure
REQ-036 Op encodings, FSM state encoding and SP_RESET default SHALL reside in shared package proc_pkg.
REQ-037 Stack pointer register with inc/dec SHALL be sub-module stack_pointer.

Verification
REQ-038 Reset, PUSH 16'hAAAA, PUSH 16'h5555 -> mem[07FF]=AAAA, mem[07FE]=5555, SP=07FD.
REQ-039 Then POP twice -> wbMemData 5555 then AAAA, wbMemOrReg=1, SP=07FF.
REQ-040 PUSH32 32'h1234_ABCD then POP32 -> stall high one cycle each, wbPop32=1234ABCD, SP=07FF.
REQ-041 POP at SP=07FF -> stackErr pulse, SP=0800.
REQ-042 STORE 16'hBEEF at 0x0010, LOAD 0x0010 -> wbMemData=BEEF in N+1, wbRegWrite=1.
REQ-043 rst asserted in BEAT2 of PUSH32 -> only high word written, SP=07FF, state IDLE.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the memory stage: op encodings, FSM states,
// stack pointer reset default and small op-classification helpers.
package proc_pkg;

  // Memory-stage operation codes; code 7 is reserved and behaves as NOP.
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_PUSH   = 3'd3,
    OP_POP    = 3'd4,
    OP_PUSH32 = 3'd5,
    OP_POP32  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  // IDLE accepts a new op; BEAT2 issues the second word of a 32-bit stack op.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } state_e;

  // Empty-stack pointer value; the first push lands here.
  localparam logic [15:0] SP_RESET_DEFAULT = 16'h07FF;

  // True for the two-beat stack ops.
  function automatic logic is_wide(op_e o);
    return (o == OP_PUSH32) || (o == OP_POP32);
  endfunction

  // True for single-beat ops whose result comes from memory.
  function automatic logic is_mem_read(op_e o);
    return (o == OP_LOAD) || (o == OP_POP);
  endfunction

  // True for any op that pops the stack.
  function automatic logic is_pop(op_e o);
    return (o == OP_POP) || (o == OP_POP32);
  endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register. The stack grows downward; the pointer always
// addresses the next free slot. Arithmetic wraps modulo 2^ADDR_W.
module stack_pointer
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp
);

  logic [ADDR_W-1:0] sp_reg;

  // Step the pointer by one per request; simultaneous inc/dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg <= SP_RESET;
    end else if (inc && !dec) begin
      sp_reg <= sp_reg + ADDR_W'(1);
    end else if (dec && !inc) begin
      sp_reg <= sp_reg - ADDR_W'(1);
    end
  end

  assign sp = sp_reg;

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues data-memory requests for loads, stores and
// 16/32-bit stack ops, tracks the stack pointer, and registers the
// write-back controls. 32-bit stack ops take two beats and stall upstream
// for the accept cycle only; the second beat uses fields captured then.
module memory_stage
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              opValid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       storeData,
  input  logic [DATA_W-1:0] aluData,
  input  logic [2:0]        regDst,
  input  logic              regWrite,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic              dmemWe,
  output logic [DATA_W-1:0] dmemWdata,
  input  logic [DATA_W-1:0] dmemRdata,
  output logic              stall,
  output logic              wbMemOrReg,
  output logic [DATA_W-1:0] wbMemData,
  output logic [DATA_W-1:0] wbAluData,
  output logic [2:0]        wbRegDst,
  output logic              wbRegWrite,
  output logic [31:0]       wbPop32,
  output logic              stackErr
);

  // FSM and second-beat context
  state_e            state_reg;
  logic              beat_push_reg;   // second beat belongs to PUSH32 (else POP32)
  logic [DATA_W-1:0] low_wdata_reg;   // PUSH32 low word, written in the second beat
  logic [2:0]        hold_dst_reg;
  logic              hold_write_reg;
  logic [DATA_W-1:0] hold_alu_reg;
  logic [DATA_W-1:0] pop_low_reg;     // POP32 low word, arrives during the second beat

  // Write-back registers
  logic              wb_mem_or_reg_reg;
  logic              wb_reg_write_reg;
  logic [2:0]        wb_reg_dst_reg;
  logic [DATA_W-1:0] wb_alu_data_reg;

  // Stack pointer interface
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_plus1;
  logic              sp_inc;
  logic              sp_dec;

  // Combinational request for the current cycle
  op_e               op_in;
  logic              accept_wide;
  logic              accept_read;
  logic [ADDR_W-1:0] addr_next;
  logic              we_next;
  logic [DATA_W-1:0] wdata_next;
  logic              stall_next;
  logic              err_next;

  assign op_in       = op_e'(op);
  assign sp_plus1    = sp + ADDR_W'(1);
  assign accept_wide = (state_reg == ST_IDLE) && opValid && is_wide(op_in);
  assign accept_read = opValid && is_mem_read(op_in);

  stack_pointer #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_stack_pointer (
    .clk (clk),
    .rst (rst),
    .inc (sp_inc),
    .dec (sp_dec),
    .sp  (sp)
  );

  // Decode the memory request and stack pointer step for this cycle.
  always_comb begin
    addr_next  = addr;
    we_next    = 1'b0;
    wdata_next = DATA_W'(storeData[15:0]);
    stall_next = 1'b0;
    err_next   = 1'b0;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    if (state_reg == ST_BEAT2) begin
      // Second beat: op inputs are ignored, captured context drives memory.
      wdata_next = low_wdata_reg;
      if (beat_push_reg) begin
        addr_next = sp;
        we_next   = 1'b1;
        sp_dec    = 1'b1;
      end else begin
        addr_next = sp_plus1;
        sp_inc    = 1'b1;
      end
    end else if (opValid) begin
      case (op_in)
        OP_LOAD: begin
          addr_next = addr;
        end
        OP_STORE: begin
          addr_next = addr;
          we_next   = 1'b1;
        end
        OP_PUSH: begin
          addr_next = sp;
          we_next   = 1'b1;
          sp_dec    = 1'b1;
        end
        OP_POP: begin
          addr_next = sp_plus1;
          sp_inc    = 1'b1;
          err_next  = (sp == SP_RESET);
        end
        OP_PUSH32: begin
          addr_next  = sp;
          we_next    = 1'b1;
          wdata_next = DATA_W'(storeData[31:16]);
          sp_dec     = 1'b1;
          stall_next = 1'b1;
        end
        OP_POP32: begin
          addr_next  = sp_plus1;
          sp_inc     = 1'b1;
          err_next   = (sp == SP_RESET);
          stall_next = 1'b1;
        end
        default: begin
          we_next = 1'b0;
        end
      endcase
    end
  end

  // Two-state sequencer; captures second-beat context when a wide op is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      beat_push_reg  <= 1'b0;
      low_wdata_reg  <= '0;
      hold_dst_reg   <= '0;
      hold_write_reg <= 1'b0;
      hold_alu_reg   <= '0;
    end else if (state_reg == ST_BEAT2) begin
      state_reg <= ST_IDLE;
    end else if (accept_wide) begin
      state_reg      <= ST_BEAT2;
      beat_push_reg  <= (op_in == OP_PUSH32);
      low_wdata_reg  <= DATA_W'(storeData[15:0]);
      hold_dst_reg   <= regDst;
      hold_write_reg <= regWrite;
      hold_alu_reg   <= aluData;
    end
  end

  // Register write-back controls at the end of each op's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_mem_or_reg_reg <= 1'b0;
      wb_reg_write_reg  <= 1'b0;
      wb_reg_dst_reg    <= '0;
      wb_alu_data_reg   <= '0;
      pop_low_reg       <= '0;
    end else if (state_reg == ST_BEAT2) begin
      wb_mem_or_reg_reg <= !beat_push_reg;
      wb_reg_write_reg  <= hold_write_reg && !beat_push_reg;
      wb_reg_dst_reg    <= hold_dst_reg;
      wb_alu_data_reg   <= hold_alu_reg;
      if (!beat_push_reg) begin
        pop_low_reg <= dmemRdata;
      end
    end else if (accept_wide) begin
      // Bubble between the two beats so nothing is written back twice.
      wb_mem_or_reg_reg <= 1'b0;
      wb_reg_write_reg  <= 1'b0;
    end else begin
      wb_mem_or_reg_reg <= accept_read;
      wb_reg_write_reg  <= accept_read && regWrite;
      wb_reg_dst_reg    <= regDst;
      wb_alu_data_reg   <= aluData;
    end
  end

  // Outputs; the combinational strobes and read-data paths are held low in reset.
  assign dmemAddr   = addr_next;
  assign dmemWe     = we_next && !rst;
  assign dmemWdata  = wdata_next;
  assign stall      = stall_next && !rst;
  assign stackErr   = err_next && !rst;
  assign wbMemOrReg = wb_mem_or_reg_reg;
  assign wbRegWrite = wb_reg_write_reg;
  assign wbRegDst   = wb_reg_dst_reg;
  assign wbAluData  = wb_alu_data_reg;
  assign wbMemData  = rst ? '0 : dmemRdata;
  assign wbPop32    = rst ? 32'h0 : {dmemRdata[15:0], pop_low_reg[15:0]};

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table of single-cycle vectors plus
// hand-written sequences for PUSH32/POP32, empty-stack pop and reset in BEAT2.
module tb_memory_stage;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        opValid;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [31:0] storeData;
  logic [15:0] aluData;
  logic [2:0]  regDst;
  logic        regWrite;
  logic [15:0] dmemAddr;
  logic        dmemWe;
  logic [15:0] dmemWdata;
  logic [15:0] dmemRdata;
  logic        stall;
  logic        wbMemOrReg;
  logic [15:0] wbMemData;
  logic [15:0] wbAluData;
  logic [2:0]  wbRegDst;
  logic        wbRegWrite;
  logic [31:0] wbPop32;
  logic        stackErr;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk        (clk),
    .rst        (rst),
    .opValid    (opValid),
    .op         (op),
    .addr       (addr),
    .storeData  (storeData),
    .aluData    (aluData),
    .regDst     (regDst),
    .regWrite   (regWrite),
    .dmemAddr   (dmemAddr),
    .dmemWe     (dmemWe),
    .dmemWdata  (dmemWdata),
    .dmemRdata  (dmemRdata),
    .stall      (stall),
    .wbMemOrReg (wbMemOrReg),
    .wbMemData  (wbMemData),
    .wbAluData  (wbAluData),
    .wbRegDst   (wbRegDst),
    .wbRegWrite (wbRegWrite),
    .wbPop32    (wbPop32),
    .stackErr   (stackErr)
  );

  // Synchronous-read data memory
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (dmemWe) mem[dmemAddr] <= dmemWdata;
    dmemRdata <= mem[dmemAddr];
  end

  typedef struct {
    int          due;
    logic        mor;
    logic        rw;
    logic [2:0]  dst;
    logic [15:0] alu;
    logic        full;
    logic        chk_mem;
    logic [15:0] memv;
    logic        chk_pop;
    logic [31:0] pop;
  } wb_exp_t;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] sd;
    logic [15:0] alu;
    logic [2:0]  dst;
    logic        rw;
    logic        chk_addr;
    logic [15:0] e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    logic        e_mor;
    logic        e_rw;
    logic        full;
    logic        chk_mem;
    logic [15:0] e_mem;
  } vec_t;

  wb_exp_t sb[$];
  vec_t    vt[10];
  int      cycle  = 0;
  int      checks = 0;
  int      errors = 0;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic wb_exp_t mk(int due, logic mor, logic rw, logic [2:0] dst,
                                 logic [15:0] alu, logic full, logic chk_mem,
                                 logic [15:0] memv, logic chk_pop, logic [31:0] pop);
    wb_exp_t e;
    e.due = due; e.mor = mor; e.rw = rw; e.dst = dst; e.alu = alu; e.full = full;
    e.chk_mem = chk_mem; e.memv = memv; e.chk_pop = chk_pop; e.pop = pop;
    return e;
  endfunction

  // Advance one cycle and retire every scoreboard entry due in it.
  task automatic tick();
    wb_exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    while (sb.size() != 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      chk1($sformatf("wb_mor_c%0d", cycle), wbMemOrReg, e.mor);
      chk1($sformatf("wb_rw_c%0d", cycle), wbRegWrite, e.rw);
      if (e.full) begin
        chk16($sformatf("wb_alu_c%0d", cycle), wbAluData, e.alu);
        chk16($sformatf("wb_dst_c%0d", cycle), {13'h0, wbRegDst}, {13'h0, e.dst});
      end
      if (e.chk_mem) chk16($sformatf("wb_mem_c%0d", cycle), wbMemData, e.memv);
      if (e.chk_pop) chk32($sformatf("wb_pop32_c%0d", cycle), wbPop32, e.pop);
      $display("cycle %0d wb mor=%0b rw=%0b dst=%0d alu=%h mem=%h pop32=%h",
               cycle, wbMemOrReg, wbRegWrite, wbRegDst, wbAluData, wbMemData, wbPop32);
    end
  endtask

  task automatic drive(logic v, logic [2:0] o, logic [15:0] a, logic [31:0] sd,
                       logic [15:0] alu, logic [2:0] dst, logic rw);
    opValid = v; op = o; addr = a; storeData = sd; aluData = alu; regDst = dst; regWrite = rw;
    #1;
  endtask

  task automatic nop_cycle();
    tick();
    drive(1'b1, OP_NOP, 16'h0, 32'h0, 16'h0, 3'd0, 1'b0);
    chk1("nop_we", dmemWe, 1'b0);
    sb.push_back(mk(cycle + 1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       v     op         addr      sd            alu       dst   rw    chka  e_addr    we    wdata     mor   rw    full  chkm  mem
    vt[0] = '{1'b1, OP_PUSH,  16'h0000, 32'h0000AAAA, 16'h1111, 3'd1, 1'b1, 1'b1, 16'h07FF, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[1] = '{1'b1, OP_PUSH,  16'h0000, 32'h00005555, 16'h1212, 3'd2, 1'b1, 1'b1, 16'h07FE, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[2] = '{1'b1, OP_POP,   16'h0000, 32'h00000000, 16'h2222, 3'd2, 1'b1, 1'b1, 16'h07FE, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555};
    vt[3] = '{1'b1, OP_POP,   16'h0000, 32'h00000000, 16'h2323, 3'd3, 1'b1, 1'b1, 16'h07FF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA};
    vt[4] = '{1'b1, OP_STORE, 16'h0010, 32'h0000BEEF, 16'h2424, 3'd4, 1'b1, 1'b1, 16'h0010, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[5] = '{1'b1, OP_LOAD,  16'h0010, 32'h00000000, 16'h3333, 3'd5, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF};
    vt[6] = '{1'b0, OP_STORE, 16'h0011, 32'h00001111, 16'h0000, 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[7] = '{1'b1, OP_RSVD,  16'h0012, 32'h00002222, 16'h0000, 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[8] = '{1'b1, OP_NOP,   16'h0013, 32'h00003333, 16'h0000, 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[9] = '{1'b1, OP_LOAD,  16'h07FF, 32'h00000000, 16'h4545, 3'd6, 1'b0, 1'b1, 16'h07FF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hAAAA};

    // Reset with a wide op presented: strobes must stay low.
    rst = 1'b1;
    drive(1'b1, OP_PUSH32, 16'h0, 32'hFFFFFFFF, 16'hFFFF, 3'd7, 1'b1);
    tick();
    tick();
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_we", dmemWe, 1'b0);
    chk1("rst_err", stackErr, 1'b0);
    chk1("rst_wb_rw", wbRegWrite, 1'b0);
    chk1("rst_wb_mor", wbMemOrReg, 1'b0);
    chk16("rst_wb_alu", wbAluData, 16'h0);
    chk16("rst_wb_mem", wbMemData, 16'h0);
    chk16("rst_sp", dut.sp, 16'h07FF);
    $display("cycle %0d reset state checked", cycle);
    tick();
    rst = 1'b0;
    drive(1'b1, OP_NOP, 16'h0, 32'h0, 16'h0, 3'd0, 1'b0);
    sb.push_back(mk(cycle + 1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0));

    // Table-driven single-cycle ops
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(vt[i].v, vt[i].op, vt[i].addr, vt[i].sd, vt[i].alu, vt[i].dst, vt[i].rw);
      if (vt[i].chk_addr) chk16($sformatf("v%0d_addr", i), dmemAddr, vt[i].e_addr);
      chk1($sformatf("v%0d_we", i), dmemWe, vt[i].e_we);
      if (vt[i].e_we) chk16($sformatf("v%0d_wdata", i), dmemWdata, vt[i].e_wdata);
      chk1($sformatf("v%0d_stall", i), stall, 1'b0);
      chk1($sformatf("v%0d_err", i), stackErr, 1'b0);
      $display("cycle %0d vec %0d op=%0d addr=%h we=%0b wdata=%h", cycle, i, op, dmemAddr, dmemWe, dmemWdata);
      sb.push_back(mk(cycle + 1, vt[i].e_mor, vt[i].e_rw, vt[i].dst, vt[i].alu, vt[i].full,
                      vt[i].chk_mem, vt[i].e_mem, 1'b0, 32'h0));
    end
    nop_cycle();
    chk16("tbl_sp", dut.sp, 16'h07FF);
    chk16("tbl_mem_07ff", mem[16'h07FF], 16'hAAAA);
    chk16("tbl_mem_07fe", mem[16'h07FE], 16'h5555);

    // PUSH32: high word at SP, low word at SP-1, stall in accept cycle only.
    tick();
    drive(1'b1, OP_PUSH32, 16'h0, 32'h1234ABCD, 16'h5A5A, 3'd1, 1'b1);
    chk1("p32_n_stall", stall, 1'b1);
    chk16("p32_n_addr", dmemAddr, 16'h07FF);
    chk1("p32_n_we", dmemWe, 1'b1);
    chk16("p32_n_wdata", dmemWdata, 16'h1234);
    $display("cycle %0d push32 beat1 addr=%h wdata=%h", cycle, dmemAddr, dmemWdata);
    sb.push_back(mk(cycle + 1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0));
    sb.push_back(mk(cycle + 2, 1'b0, 1'b0, 3'd1, 16'h5A5A, 1'b1, 1'b0, 16'h0, 1'b0, 32'h0));
    tick();
    drive(1'b1, OP_STORE, 16'h0020, 32'h0000DEAD, 16'h0, 3'd0, 1'b1);
    chk1("p32_n1_stall", stall, 1'b0);
    chk16("p32_n1_addr", dmemAddr, 16'h07FE);
    chk1("p32_n1_we", dmemWe, 1'b1);
    chk16("p32_n1_wdata", dmemWdata, 16'hABCD);
    $display("cycle %0d push32 beat2 addr=%h wdata=%h", cycle, dmemAddr, dmemWdata);
    nop_cycle();
    chk16("p32_sp", dut.sp, 16'h07FD);
    chk16("p32_mem_hi", mem[16'h07FF], 16'h1234);
    chk16("p32_mem_lo", mem[16'h07FE], 16'hABCD);
    chk16("p32_ignored_store", mem[16'h0020], 16'h0000);

    // POP32: low from SP+1, high from SP+2, assembled result in N+2.
    tick();
    drive(1'b1, OP_POP32, 16'h0, 32'h0, 16'h4444, 3'd6, 1'b1);
    chk1("q32_n_stall", stall, 1'b1);
    chk16("q32_n_addr", dmemAddr, 16'h07FE);
    chk1("q32_n_we", dmemWe, 1'b0);
    chk1("q32_n_err", stackErr, 1'b0);
    $display("cycle %0d pop32 beat1 addr=%h", cycle, dmemAddr);
    sb.push_back(mk(cycle + 1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0));
    sb.push_back(mk(cycle + 2, 1'b1, 1'b1, 3'd6, 16'h4444, 1'b1, 1'b1, 16'h1234, 1'b1, 32'h1234ABCD));
    tick();
    drive(1'b1, OP_PUSH, 16'h0, 32'h00009999, 16'h0, 3'd0, 1'b0);
    chk1("q32_n1_stall", stall, 1'b0);
    chk16("q32_n1_addr", dmemAddr, 16'h07FF);
    chk1("q32_n1_we", dmemWe, 1'b0);
    $display("cycle %0d pop32 beat2 addr=%h", cycle, dmemAddr);
    nop_cycle();
    chk16("q32_sp", dut.sp, 16'h07FF);

    // POP from empty stack: error pulse, wraps through to 0800.
    tick();
    drive(1'b1, OP_POP, 16'h0, 32'h0, 16'h7777, 3'd7, 1'b1);
    chk1("empty_err", stackErr, 1'b1);
    chk16("empty_addr", dmemAddr, 16'h0800);
    $display("cycle %0d empty pop err=%0b addr=%h", cycle, stackErr, dmemAddr);
    sb.push_back(mk(cycle + 1, 1'b1, 1'b1, 3'd7, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0, 32'h0));
    nop_cycle();
    chk1("empty_err_clear", stackErr, 1'b0);
    chk16("empty_sp", dut.sp, 16'h0800);

    // Reset during BEAT2 of PUSH32 aborts the low-word write.
    tick();
    rst = 1'b1;
    drive(1'b1, OP_NOP, 16'h0, 32'h0, 16'h0, 3'd0, 1'b0);
    sb.delete();
    tick();
    rst = 1'b0;
    drive(1'b1, OP_PUSH32, 16'h0, 32'hCAFEF00D, 16'h0, 3'd0, 1'b1);
    chk1("rb2_n_stall", stall, 1'b1);
    chk16("rb2_n_addr", dmemAddr, 16'h07FF);
    tick();
    rst = 1'b1;
    drive(1'b1, OP_NOP, 16'h0, 32'h0, 16'h0, 3'd0, 1'b0);
    chk1("rb2_we", dmemWe, 1'b0);
    chk1("rb2_stall", stall, 1'b0);
    chk1("rb2_wb_rw", wbRegWrite, 1'b0);
    chk1("rb2_wb_mor", wbMemOrReg, 1'b0);
    chk16("rb2_wb_mem", wbMemData, 16'h0);
    chk32("rb2_wb_pop32", wbPop32, 32'h0);
    chk1("rb2_state", logic'(dut.state_reg), 1'b0);
    chk16("rb2_sp", dut.sp, 16'h07FF);
    $display("cycle %0d reset in beat2 we=%0b", cycle, dmemWe);
    tick();
    rst = 1'b0;
    drive(1'b1, OP_NOP, 16'h0, 32'h0, 16'h0, 3'd0, 1'b0);
    chk1("rb2_after_we", dmemWe, 1'b0);
    sb.push_back(mk(cycle + 1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0));
    nop_cycle();
    chk16("rb2_mem_hi", mem[16'h07FF], 16'hCAFE);
    chk16("rb2_mem_lo", mem[16'h07FE], 16'hABCD);
    chk16("rb2_sp_final", dut.sp, 16'h07FF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
